sine_phase_scheduler: RTL and testbench
=======================================

# sine_phase_scheduler

- Drives a shared quarter-wave sine ROM (128 × 10-bit, synchronous read, 1-cycle latency) for two independent output channels, A and B.
- Each channel has a phase accumulator with a programmable tuning word.
- ROM accesses for the two channels are time-multiplexed in a fixed 3-cycle frame.
- Quadrant folding is applied to each ROM word: address mirroring plus output inversion about full scale. Each channel gets a registered 10-bit sample with a valid pulse, for the parallel DAC pins.

## Interface

Parameters:
- PHASE_W, 16, phase accumulator width. Top 2 bits select the quadrant; the next 7 bits are the table index.
- ADDR_W, 7, ROM address width (128-entry quarter table).
- DATA_W, 10, sample width; full scale is 2^DATA_W−1 = 1023.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled at frame boundaries.
- sync  in  1  clears both phase accumulators at the next S_UPD.
- tune_a  in  PHASE_W  channel A phase increment per frame.
- tune_b  in  PHASE_W  channel B phase increment per frame.
- rom_addr  out  ADDR_W  address to the shared ROM.
- rom_data  in  DATA_W  ROM read data; valid one cycle after rom_addr.
- sample_a  out  DATA_W  channel A sample (registered).
- sample_b  out  DATA_W  channel B sample (registered).
- valid_a  out  1  one-cycle pulse when sample_a updates.
- valid_b  out  1  one-cycle pulse when sample_b updates.

## Operation

- **States:** S_IDLE, S_A, S_B, S_UPD.
- **S_IDLE**
  - Outputs hold; rom_addr = 0.
  - Goes to S_A on the next edge if enable = 1.
- **S_A**
  - rom_addr = fold(phase_a).
  - Registers the quadrant of phase_a into q_a.
  - Next state: S_B.
- **S_B**
  - rom_addr = fold(phase_b); registers q_b.
  - On the exit edge: sample_a ← out(q_a, rom_data); valid_a pulses for 1 cycle.
  - Next state: S_UPD.
- **S_UPD**
  - rom_addr holds fold(phase_b).
  - On the exit edge: sample_b ← out(q_b, rom_data); valid_b pulses for 1 cycle.
  - Phase update on the same edge:
    - sync = 0: phase_a ← phase_a + tune_a and phase_b ← phase_b + tune_b, both mod 2^PHASE_W (carry discarded).
    - sync = 1: both phases ← 0.
  - Next state: S_A if enable = 1, else S_IDLE.
- **Quadrant and index:** q = phase[PHASE_W-1:PHASE_W-2]; idx = phase[PHASE_W-3 -: ADDR_W].
- **fold:**
  - q ∈ {0, 2}: rom_addr = idx.
  - q ∈ {1, 3}: rom_addr = 127 − idx.
- **out:**
  - q ∈ {0, 1}: rom_data.
  - q ∈ {2, 3}: 1023 − rom_data, an unsigned DATA_W subtraction that never underflows.
- **Timing of control inputs:**
  - enable deasserted mid-frame: the current frame completes (both samples and the phase update), then S_IDLE.
  - sync is only honoured in S_UPD; asserting it in other states has no effect. sync takes priority over the tune add.
  - tune_a and tune_b are sampled only at the S_UPD edge; changes at other times do not disturb the frame in progress.

## Timing

- **Reset values (immediate on rst_n low):**
  - state = S_IDLE, phase_a = phase_b = 0, q_a = q_b = 0.
  - rom_addr = 0, sample_a = sample_b = 512.
  - valid_a = valid_b = 0.
- **Reset mid-frame:** the frame is abandoned, with no partial sample update.
- **Frame period:** 3 cycles. Each channel gets one sample per frame.
- **Start latency:** enable is high before edge 0.
  - Edge 0: S_IDLE → S_A.
  - Edge 2: valid_a is asserted after it (cycle 2).
  - Edge 3: valid_b is asserted after it (cycle 3).
- **Frame-to-frame:** valid_a and valid_b each pulse once per frame, 1 cycle apart, never simultaneously.
- **Phase visibility:** the first frame after enable uses phase 0. A phase update becomes visible to the ROM address in the immediately following S_A.
- **rom_addr:** combinational from the state and the registered phases, so it is glitch-free at edges.

## Test plan

Use a ROM model with rom[i] = i.

1. **Reset:** hold rst_n = 0 mid-frame -> all outputs at their reset values immediately; after release the block stays in S_IDLE while enable = 0.
2. **DC channel:** tune_a = 0, enable = 1 -> sample_a = 0, with valid_a every 3 cycles, first pulse 2 cycles after leaving S_IDLE.
3. **Quadrant walk:** tune_a = 0x4000 -> successive sample_a values are 0, 127, 1023, 896, 0; rom_addr in S_A runs 0, 127, 0, 127.
4. **Index step:** tune_b = 0x0080 -> sample_b runs 0, 1, 2, …, 127, then 127, 126, … (quadrant 1 mirror), then 1023, 1022, … in quadrant 2.
5. **Sync and enable:**
   - sync pulsed during S_UPD with phase_a = 0x8000 -> the next sample_a is 0.
   - sync pulsed in S_A -> ignored.
   - enable dropped in S_B -> valid_b still fires, then S_IDLE with the samples held.
6. **Wrap-around:** tune_a = 0xFFFF starting from phase 0 -> phase_a = 0xFFFF, then 0xFFFE. The q = 3, idx = 127 mapping gives rom_addr = 0 and sample_a = 1023.

Source files
------------

// File: rtl/sine_phase_scheduler.sv
// sine_phase_scheduler
// Two-channel sine generator sharing one quarter-wave ROM. The ROM has a
// 1-cycle read latency. A fixed 3-cycle frame (S_A, S_B, S_UPD) serves
// channel A, then channel B, then advances both phase accumulators.
// Each ROM word is folded into the full wave:
//   - the address is mirrored in odd quadrants;
//   - the data is inverted about full scale in the lower half-wave.
module sine_phase_scheduler #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               sync,
    input  logic [PHASE_W-1:0] tune_a,
    input  logic [PHASE_W-1:0] tune_b,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [DATA_W-1:0]  sample_a,
    output logic [DATA_W-1:0]  sample_b,
    output logic               valid_a,
    output logic               valid_b
);

    // Frame sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_A    = 2'd1,
        S_B    = 2'd2,
        S_UPD  = 2'd3
    } state_t;

    // Full scale (all ones), mid scale (idle/reset output level) and last
    // table entry (the mirror point).
    localparam logic [DATA_W-1:0] FULL_SCALE = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] MID_SCALE  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};

    // Mirrors the table index in quadrants 1 and 3, so the quarter table is
    // walked backwards on the falling side of each half-wave.
    function automatic logic [ADDR_W-1:0] fold_addr(
        input logic [1:0]        q,
        input logic [ADDR_W-1:0] idx
    );
        if (q[0]) begin
            return ADDR_MAX - idx;
        end else begin
            return idx;
        end
    endfunction

    // Inverts the table word about full scale in quadrants 2 and 3 (the
    // negative half-wave). FULL_SCALE >= any word, so this cannot underflow.
    function automatic logic [DATA_W-1:0] fold_out(
        input logic [1:0]        q,
        input logic [DATA_W-1:0] data
    );
        if (q[1]) begin
            return FULL_SCALE - data;
        end else begin
            return data;
        end
    endfunction

    state_t              r_state;
    state_t              w_state_next;

    logic [PHASE_W-1:0]  r_phase_a;
    logic [PHASE_W-1:0]  r_phase_b;
    logic [1:0]          r_q_a;
    logic [1:0]          r_q_b;

    logic [1:0]          w_q_a;
    logic [1:0]          w_q_b;
    logic [ADDR_W-1:0]   w_idx_a;
    logic [ADDR_W-1:0]   w_idx_b;

    logic                w_cap_q_a;
    logic                w_cap_q_b;
    logic                w_load_a;
    logic                w_load_b;

    // Quadrant is the top two phase bits; the table index is the next
    // ADDR_W bits. The low phase bits only provide fractional resolution.
    assign w_q_a   = r_phase_a[PHASE_W-1 -: 2];
    assign w_q_b   = r_phase_b[PHASE_W-1 -: 2];
    assign w_idx_a = r_phase_a[PHASE_W-3 -: ADDR_W];
    assign w_idx_b = r_phase_b[PHASE_W-3 -: ADDR_W];

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, ROM address and per-state strobes.
    // rom_addr is decoded only from registered state and phases, so it
    // cannot glitch after an edge.
    always_comb begin
        w_state_next = r_state;
        rom_addr     = {ADDR_W{1'b0}};
        w_cap_q_a    = 1'b0;
        w_cap_q_b    = 1'b0;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        case (r_state)
            S_IDLE: begin
                rom_addr = {ADDR_W{1'b0}};
                if (enable) begin
                    w_state_next = S_A;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_A: begin
                rom_addr     = fold_addr(w_q_a, w_idx_a);
                w_cap_q_a    = 1'b1;
                w_state_next = S_B;
            end
            S_B: begin
                // ROM data for channel A arrives here; channel B is
                // addressed in the same cycle.
                rom_addr     = fold_addr(w_q_b, w_idx_b);
                w_cap_q_b    = 1'b1;
                w_load_a     = 1'b1;
                w_state_next = S_UPD;
            end
            S_UPD: begin
                // Hold B's address; channel B data is returned in this cycle.
                rom_addr = fold_addr(w_q_b, w_idx_b);
                w_load_b = 1'b1;
                if (enable) begin
                    w_state_next = S_A;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                rom_addr     = {ADDR_W{1'b0}};
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Phase accumulators advance once per frame on the S_UPD exit edge.
    // sync overrides the tuning add; the carry out of the MSB is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_a <= {PHASE_W{1'b0}};
            r_phase_b <= {PHASE_W{1'b0}};
        end else if (w_load_b) begin
            if (sync) begin
                r_phase_a <= {PHASE_W{1'b0}};
                r_phase_b <= {PHASE_W{1'b0}};
            end else begin
                r_phase_a <= r_phase_a + tune_a;
                r_phase_b <= r_phase_b + tune_b;
            end
        end else begin
            r_phase_a <= r_phase_a;
            r_phase_b <= r_phase_b;
        end
    end

    // Remember each channel's quadrant while its ROM read is in flight,
    // so the inversion matches the address that was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_a <= 2'd0;
            r_q_b <= 2'd0;
        end else begin
            if (w_cap_q_a) begin
                r_q_a <= w_q_a;
            end else begin
                r_q_a <= r_q_a;
            end
            if (w_cap_q_b) begin
                r_q_b <= w_q_b;
            end else begin
                r_q_b <= r_q_b;
            end
        end
    end

    // Channel A output register and its one-cycle valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_a <= MID_SCALE;
            valid_a  <= 1'b0;
        end else begin
            valid_a <= w_load_a;
            if (w_load_a) begin
                sample_a <= fold_out(r_q_a, rom_data);
            end else begin
                sample_a <= sample_a;
            end
        end
    end

    // Channel B output register and its one-cycle valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_b <= MID_SCALE;
            valid_b  <= 1'b0;
        end else begin
            valid_b <= w_load_b;
            if (w_load_b) begin
                sample_b <= fold_out(r_q_b, rom_data);
            end else begin
                sample_b <= sample_b;
            end
        end
    end

endmodule

// File: tb/tb_sine_phase_scheduler.sv
// Self-checking bench for sine_phase_scheduler.
// A synchronous ROM model feeds the DUT. Expected samples and addresses
// come from a frame-level model: two phase integers plus the
// quadrant-folding rules.
module tb_sine_phase_scheduler;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        enable   = 1'b0;
    logic        sync     = 1'b0;
    logic [15:0] tune_a   = 16'd0;
    logic [15:0] tune_b   = 16'd0;
    logic [6:0]  rom_addr;
    logic [9:0]  rom_data;
    logic [9:0]  sample_a;
    logic [9:0]  sample_b;
    logic        valid_a;
    logic        valid_b;

    logic [9:0]  rom [0:127];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned m_pa   = 0;
    int unsigned m_pb   = 0;
    logic [9:0]  ga;
    logic [9:0]  gb;

    sine_phase_scheduler #(.PHASE_W(16), .ADDR_W(7), .DATA_W(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .sync     (sync),
        .tune_a   (tune_a),
        .tune_b   (tune_b),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sample_a (sample_a),
        .sample_b (sample_b),
        .valid_a  (valid_a),
        .valid_b  (valid_b)
    );

    always #5 clk = ~clk;

    // Shared ROM: synchronous read, data one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: which table entry a phase reads.
    function automatic int ref_addr(input int unsigned p);
        int q;
        int idx;
        q   = int'((p / 16384) % 4);
        idx = int'((p / 128) % 128);
        return (q % 2 == 1) ? (127 - idx) : idx;
    endfunction

    // Model: the sine value a phase should produce.
    function automatic int ref_sample(input int unsigned p);
        int q;
        int a;
        q = int'((p / 16384) % 4);
        a = ref_addr(p);
        return (q >= 2) ? (1023 - int'(rom[a])) : int'(rom[a]);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One frame. Called one cycle after the edge that entered S_A. Junk
    // values for sync/tune/enable are driven in S_A/S_B; the real values
    // are driven only in S_UPD.
    task automatic frame(input logic [15:0] ta, input logic [15:0] tb,
                         input logic sy, input logic en_after,
                         output logic [9:0] got_a, output logic [9:0] got_b);
        int ea;
        int eb;
        ea = ref_sample(m_pa);
        eb = ref_sample(m_pb);
        chk("addr_SA", 32'(rom_addr), ref_addr(m_pa));
        sync   = 1'($urandom_range(0, 1));
        tune_a = 16'($urandom);
        tune_b = 16'($urandom);
        enable = 1'($urandom_range(0, 1));
        tick;
        chk("addr_SB", 32'(rom_addr), ref_addr(m_pb));
        chk("valid_a_early", 32'(valid_a), 0);
        sync   = 1'($urandom_range(0, 1));
        tune_a = 16'($urandom);
        tune_b = 16'($urandom);
        enable = en_after;
        tick;
        chk("valid_a", 32'(valid_a), 1);
        chk("sample_a", 32'(sample_a), ea);
        chk("valid_b_early", 32'(valid_b), 0);
        chk("addr_UPD", 32'(rom_addr), ref_addr(m_pb));
        got_a  = sample_a;
        tune_a = ta;
        tune_b = tb;
        sync   = sy;
        enable = en_after;
        tick;
        chk("valid_b", 32'(valid_b), 1);
        chk("sample_b", 32'(sample_b), eb);
        chk("valid_a_late", 32'(valid_a), 0);
        got_b = sample_b;
        if (sy) begin
            m_pa = 0;
            m_pb = 0;
        end else begin
            m_pa = (m_pa + 32'(ta)) % 65536;
            m_pb = (m_pb + 32'(tb)) % 65536;
        end
        sync = 1'b0;
        if (en_after) begin
            chk("addr_next", 32'(rom_addr), ref_addr(m_pa));
        end else begin
            chk("addr_idle", 32'(rom_addr), 0);
        end
    endtask

    // While idle: no strobes, address 0, samples held.
    task automatic idle_check(input int n);
        logic [9:0] sa;
        logic [9:0] sb;
        sa = sample_a;
        sb = sample_b;
        for (int i = 0; i < n; i++) begin
            tick;
            chk("idle_addr", 32'(rom_addr), 0);
            chk("idle_valid_a", 32'(valid_a), 0);
            chk("idle_valid_b", 32'(valid_b), 0);
            chk("idle_hold_a", 32'(sample_a), 32'(sa));
            chk("idle_hold_b", 32'(sample_b), 32'(sb));
        end
    endtask

    initial begin
        int qexp [5];
        int expk;
        logic [15:0] rta;
        logic [15:0] rtb;
        logic rsy;
        logic ren;

        qexp = '{0, 127, 1023, 896, 0};
        for (int i = 0; i < 128; i++) rom[i] = 10'(i);

        // Power-on reset.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_sample_a", 32'(sample_a), 512);
        chk("rst_sample_b", 32'(sample_b), 512);
        chk("rst_valid_a", 32'(valid_a), 0);
        chk("rst_valid_b", 32'(valid_b), 0);
        @(negedge clk) rst_n = 1'b1;
        idle_check(3);

        // DC channel: zero tuning gives a constant 0 sample.
        enable = 1'b1;
        tick;
        for (int k = 0; k < 3; k++) begin
            frame(16'h0000, 16'h0000, 1'b0, 1'b1, ga, gb);
            chk("dc_a", 32'(ga), 0);
        end

        // Quadrant walk on channel A.
        for (int k = 0; k < 5; k++) begin
            frame(16'h4000, 16'h0000, 1'b0, 1'b1, ga, gb);
            chk("quad_walk", 32'(ga), qexp[k]);
        end

        // Reset in the middle of a frame (state S_B).
        tick;
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(rom_addr), 0);
        chk("mid_rst_sample_a", 32'(sample_a), 512);
        chk("mid_rst_sample_b", 32'(sample_b), 512);
        chk("mid_rst_valid_a", 32'(valid_a), 0);
        chk("mid_rst_valid_b", 32'(valid_b), 0);
        m_pa = 0;
        m_pb = 0;
        enable = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        idle_check(4);

        // Index step on channel B.
        enable = 1'b1;
        tick;
        frame(16'h0000, 16'h0000, 1'b1, 1'b1, ga, gb);
        for (int k = 0; k < 300; k++) begin
            frame(16'($urandom), 16'h0080, 1'b0, 1'b1, ga, gb);
            if (k < 128)      expk = k;
            else if (k < 256) expk = 255 - k;
            else              expk = 1023 - (k - 256);
            chk("idx_step", 32'(gb), expk);
        end

        // Sync in S_UPD clears the phases; sync elsewhere is ignored.
        frame(16'h0000, 16'h0000, 1'b1, 1'b1, ga, gb);
        frame(16'h4000, 16'h0000, 1'b0, 1'b1, ga, gb);
        frame(16'h4000, 16'h0000, 1'b0, 1'b1, ga, gb);
        frame(16'h1234, 16'h0040, 1'b1, 1'b1, ga, gb);
        chk("sync_pre", 32'(ga), 1023);
        frame(16'h0000, 16'h0000, 1'b0, 1'b1, ga, gb);
        chk("sync_clear", 32'(ga), 0);

        // Enable dropped in S_B: the frame completes, then idle.
        frame(16'h0100, 16'h0200, 1'b0, 1'b0, ga, gb);
        idle_check(5);

        // Wrap-around with an all-ones tuning word.
        enable = 1'b1;
        tick;
        frame(16'h0000, 16'h0000, 1'b1, 1'b1, ga, gb);
        frame(16'hFFFF, 16'h0000, 1'b0, 1'b1, ga, gb);
        chk("wrap_first", 32'(ga), 0);
        chk("wrap_addr", 32'(rom_addr), 0);
        frame(16'hFFFF, 16'h0000, 1'b0, 1'b1, ga, gb);
        chk("wrap_ffff", 32'(ga), 1023);
        frame(16'hFFFF, 16'h0000, 1'b0, 1'b1, ga, gb);
        chk("wrap_fffe", 32'(ga), 1023);

        // Random ROM contents and random control traffic.
        for (int i = 0; i < 128; i++) rom[i] = 10'($urandom_range(0, 1023));
        for (int r = 0; r < 80; r++) begin
            rta = 16'($urandom);
            rtb = 16'($urandom);
            rsy = ($urandom_range(0, 9) == 0);
            ren = ($urandom_range(0, 7) != 0);
            frame(rta, rtb, rsy, ren, ga, gb);
            if (!ren) begin
                idle_check(2);
                enable = 1'b1;
                tick;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
